b16_mem_arbiter: RTL and testbench

//  Shares the single b16 memory port between the cpu core and one external bus master (DMA/host).

---
 rtl/b16_bus_pkg.sv | 20 ++
 rtl/b16_mem_mux.sv | 48 ++++
 rtl/b16_mem_arbiter.sv | 116 +++++++++++
 tb/tb_b16_mem_arbiter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/b16_bus_pkg.sv
// Shared b16 memory-bus types: port ownership states and byte-lane write encodings.
// Pure declarations; no timing or backpressure of its own.
package b16_bus_pkg;

  typedef enum logic [1:0] {
    CPU   = 2'd0,
    EXT   = 2'd1,
    GUARD = 2'd2
  } owner_t;

  localparam logic [1:0] WR_NONE = 2'b00;
  localparam logic [1:0] WR_HI   = 2'b10;
  localparam logic [1:0] WR_LO   = 2'b01;
  localparam logic [1:0] WR_WORD = 2'b11;

  function automatic logic is_read(input logic [1:0] wr);
    return wr == WR_NONE;
  endfunction

endpackage

// File: rtl/b16_mem_mux.sv
// Steers the single RAM port to the current owner and fans read data back to both masters.
// Purely combinational (0 cycles); strobes are forced idle when enable is low.
module b16_mem_mux
  import b16_bus_pkg::*;
#(
  parameter int l = 16
) (
  input  owner_t       owner,
  input  logic         enable,
  input  logic         ext_req,
  input  logic [l-1:0] cpu_addr,
  input  logic         cpu_rd,
  input  logic [1:0]   cpu_wr,
  input  logic [l-1:0] cpu_wdata,
  output logic [l-1:0] cpu_rdata,
  input  logic [l-1:0] ext_addr,
  input  logic [1:0]   ext_wr,
  input  logic [l-1:0] ext_wdata,
  output logic [l-1:0] ext_rdata,
  output logic [l-1:0] mem_addr,
  output logic         mem_rd,
  output logic [1:0]   mem_wr,
  output logic [l-1:0] mem_wdata,
  input  logic [l-1:0] mem_rdata
);

  always_comb begin
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_rd    = cpu_rd;
    mem_wr    = cpu_wr;
    if (owner == EXT) begin
      mem_addr  = ext_addr;
      mem_wdata = ext_wdata;
      // an EXT cycle without a request is an idle memory cycle
      mem_rd    = ext_req & is_read(ext_wr);
      mem_wr    = ext_req ? ext_wr : WR_NONE;
    end
    if (!enable) begin
      mem_rd = 1'b0;
      mem_wr = WR_NONE;
    end
  end

  assign cpu_rdata = mem_rdata;
  assign ext_rdata = mem_rdata;

endmodule

// File: rtl/b16_mem_arbiter.sv
// Shares the b16 RAM port between the core and an external master, stalling the core via cpu_run.
// Grant 1 cycle after ext_req; bursts capped at BURST acks, then CPU_SLOTS guard cycles for the core.
module b16_mem_arbiter
  import b16_bus_pkg::*;
#(
  parameter int l         = 16,
  parameter int BURST     = 4,
  parameter int CPU_SLOTS = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         run_in,
  output logic         cpu_run,
  input  logic [l-1:0] cpu_addr,
  input  logic         cpu_rd,
  input  logic [1:0]   cpu_wr,
  input  logic [l-1:0] cpu_wdata,
  output logic [l-1:0] cpu_rdata,
  input  logic         ext_req,
  input  logic [l-1:0] ext_addr,
  input  logic [1:0]   ext_wr,
  input  logic [l-1:0] ext_wdata,
  output logic         ext_ack,
  output logic [l-1:0] ext_rdata,
  output logic [l-1:0] mem_addr,
  output logic         mem_rd,
  output logic [1:0]   mem_wr,
  output logic [l-1:0] mem_wdata,
  input  logic [l-1:0] mem_rdata
);

  localparam int CW = $clog2(BURST + 1);
  localparam int GW = $clog2(CPU_SLOTS + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(BURST - 1);
  localparam logic [GW-1:0] GCNT_LAST = GW'(CPU_SLOTS - 1);

  owner_t        owner, owner_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [GW-1:0] gcnt, gcnt_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      owner <= CPU;
      cnt   <= '0;
      gcnt  <= '0;
    end else begin
      owner <= owner_nxt;
      cnt   <= cnt_nxt;
      gcnt  <= gcnt_nxt;
    end
  end

  always_comb begin
    owner_nxt = owner;
    cnt_nxt   = cnt;
    gcnt_nxt  = gcnt;
    case (owner)
      CPU: begin
        if (ext_req) begin
          owner_nxt = EXT;
          cnt_nxt   = '0;
        end
      end
      EXT: begin
        if (!ext_req) begin
          owner_nxt = CPU;
        end else if (cnt == CNT_LAST) begin
          owner_nxt = GUARD;
          gcnt_nxt  = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      GUARD: begin
        // requests are ignored until the last guard slot has been given to the core
        if (gcnt == GCNT_LAST) begin
          if (ext_req) begin
            owner_nxt = EXT;
            cnt_nxt   = '0;
          end else begin
            owner_nxt = CPU;
          end
        end else begin
          gcnt_nxt = gcnt + 1'b1;
        end
      end
      default: owner_nxt = CPU;
    endcase
  end

  always_comb begin
    cpu_run = run_in & ~reset & (owner != EXT);
    ext_ack = ~reset & (owner == EXT) & ext_req;
  end

  b16_mem_mux #(.l(l)) u_mux (
    .owner     (owner),
    .enable    (~reset),
    .ext_req   (ext_req),
    .cpu_addr  (cpu_addr),
    .cpu_rd    (cpu_rd),
    .cpu_wr    (cpu_wr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .ext_addr  (ext_addr),
    .ext_wr    (ext_wr),
    .ext_wdata (ext_wdata),
    .ext_rdata (ext_rdata),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

endmodule

// File: tb/tb_b16_mem_arbiter.sv
// Scoreboard bench for b16_mem_arbiter: a request-level ownership model predicts each cycle.
module tb_b16_mem_arbiter;
  import b16_bus_pkg::*;

  localparam int BURST = 4;
  localparam int SLOTS = 1;
  localparam int NCPU  = 40;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, run_in, cpu_run, cpu_rd, ext_req, ext_ack, mem_rd;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata, ext_addr, ext_wdata, ext_rdata;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  cpu_wr, ext_wr, mem_wr;

  b16_mem_arbiter #(.l(16), .BURST(BURST), .CPU_SLOTS(SLOTS)) dut (
    .clk(clk), .reset(reset), .run_in(run_in), .cpu_run(cpu_run),
    .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .ext_req(ext_req), .ext_addr(ext_addr), .ext_wr(ext_wr),
    .ext_wdata(ext_wdata), .ext_ack(ext_ack), .ext_rdata(ext_rdata),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // RAM with combinational read; preload port used only while the DUT is in reset
  logic [15:0] ram [0:65535];
  logic        pl_en;
  logic [15:0] pl_addr, pl_dat;
  assign mem_rdata = ram[mem_addr];
  always @(posedge clk) begin
    if (pl_en) ram[pl_addr] <= pl_dat;
    else begin
      if (mem_wr[1]) ram[mem_addr][15:8] <= mem_wdata[15:8];
      if (mem_wr[0]) ram[mem_addr][7:0]  <= mem_wdata[7:0];
    end
  end

  typedef struct {
    logic        ack, run, mrd;
    logic [1:0]  mwr;
    logic        chk_ext, chk_cpu;
    logic [15:0] x_rdata, c_rdata;
  } exp_t;

  exp_t        sb[$];
  exp_t        me;
  logic [15:0] ref_ram [0:65535];
  logic [15:0] golden [0:63];
  logic [15:0] c_addr [NCPU], c_dat [NCPU];
  logic [1:0]  c_wr [NCPU];
  int          errors = 0, checks = 0;
  int          guard_left, streak;
  logic        req_prev, m_ack, m_run, mon_on, ext_pend;
  logic        d_ack, d_run;
  logic [15:0] d_xrd;
  logic [9:0]  pat, rpat;

  task automatic check(input string n, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, req, $time);
    end
  endtask

  function automatic logic [15:0] merge(input logic [15:0] o, input logic [15:0] n,
                                        input logic [1:0] w);
    return {w[1] ? n[15:8] : o[15:8], w[0] ? n[7:0] : o[7:0]};
  endfunction

  // Ownership rule: memory belongs to the external master in any cycle whose
  // previous cycle had ext_req high, unless a guard window follows BURST acks.
  task automatic tick();
    exp_t        e;
    logic        grant;
    logic [15:0] wa;
    e = '{default: 0};
    grant = 1'b0;
    if (!reset) begin
      grant = (guard_left == 0) && req_prev;
      e.ack = grant && ext_req;
      e.run = run_in && !grant;
      e.mrd = grant ? (ext_req && ext_wr == WR_NONE) : cpu_rd;
      e.mwr = grant ? (ext_req ? ext_wr : WR_NONE) : cpu_wr;
      if (e.ack && ext_wr == WR_NONE) begin
        e.chk_ext = 1'b1;
        e.x_rdata = ref_ram[ext_addr];
      end
      if (!grant && cpu_rd) begin
        e.chk_cpu = 1'b1;
        e.c_rdata = ref_ram[cpu_addr];
      end
      wa = grant ? ext_addr : cpu_addr;
      if (e.mwr != WR_NONE) ref_ram[wa] = merge(ref_ram[wa], grant ? ext_wdata : cpu_wdata, e.mwr);
    end
    sb.push_back(e);
    m_ack = e.ack;
    m_run = e.run;
    if (reset) begin
      guard_left = 0; streak = 0; req_prev = 1'b0;
    end else if (guard_left > 0) begin
      guard_left--; streak = 0; req_prev = ext_req;
    end else begin
      if (e.ack) begin
        streak++;
        if (streak == BURST) begin
          guard_left = SLOTS;
          streak = 0;
        end
      end else streak = 0;
      req_prev = ext_req;
    end
    @(negedge clk);
    d_ack = ext_ack;
    d_run = cpu_run;
    d_xrd = ext_rdata;
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [15:0] a, input logic [15:0] d);
    pl_en = 1'b1; pl_addr = a; pl_dat = d;
    ref_ram[a] = d;
    @(posedge clk);
    #1;
    pl_en = 1'b0;
  endtask

  task automatic new_ext_op();
    ext_addr  = 16'h0080 + 16'($urandom_range(0, 63));
    ext_wr    = 2'($urandom_range(0, 3));
    ext_wdata = 16'($urandom);
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty at %0t", $time);
      end else begin
        me = sb.pop_front();
        check("ext_ack", 16'(ext_ack), 16'(me.ack));
        check("cpu_run", 16'(cpu_run), 16'(me.run));
        check("mem_rd", 16'(mem_rd), 16'(me.mrd));
        check("mem_wr", 16'(mem_wr), 16'(me.mwr));
        if (me.chk_ext) check("ext_rdata", ext_rdata, me.x_rdata);
        if (me.chk_cpu) check("cpu_rdata", cpu_rdata, me.c_rdata);
      end
    end
  end

  initial begin
    int cyc;
    int cpu_idx;
    reset = 1'b1; run_in = 1'b1; pl_en = 1'b0; pl_addr = '0; pl_dat = '0;
    cpu_addr = '0; cpu_rd = 1'b0; cpu_wr = WR_NONE; cpu_wdata = '0;
    ext_req = 1'b0; ext_addr = 16'h0080; ext_wr = WR_NONE; ext_wdata = '0;
    mon_on = 1'b0; ext_pend = 1'b0;
    guard_left = 0; streak = 0; req_prev = 1'b0; m_ack = 1'b0; m_run = 1'b0;
    @(posedge clk);
    #1;
    for (int a = 0; a < 64; a++) preload(16'(a), 16'($urandom));
    for (int a = 128; a < 192; a++) preload(16'(a), 16'($urandom));
    preload(16'h3F00, 16'hBEEF);
    preload(16'h0100, 16'h5566);
    for (int i = 0; i < 64; i++) golden[i] = ref_ram[i];
    for (int i = 0; i < NCPU; i++) begin
      c_addr[i] = 16'($urandom_range(0, 63));
      c_dat[i]  = 16'($urandom);
      case ($urandom_range(0, 3))
        0: c_wr[i] = WR_NONE;
        1: c_wr[i] = WR_LO;
        2: c_wr[i] = WR_HI;
        default: c_wr[i] = WR_WORD;
      endcase
      if (c_wr[i] != WR_NONE) golden[c_addr[i]] = merge(golden[c_addr[i]], c_dat[i], c_wr[i]);
    end

    // reset held with a pending external request
    mon_on = 1'b1;
    ext_req = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    ext_req = 1'b0;
    tick();
    check("post_reset_run", 16'(d_run), 16'd1);

    // single external read
    ext_addr = 16'h3F00; ext_wr = WR_NONE; ext_req = 1'b1;
    tick();
    check("t2_req_cycle_ack", 16'(d_ack), 16'd0);
    tick();
    check("t2_ack", 16'(d_ack), 16'd1);
    check("t2_rdata", d_xrd, 16'hBEEF);
    check("t2_run", 16'(d_run), 16'd0);
    ext_req = 1'b0;
    repeat (2) tick();

    // long request: burst cap and guard slot
    new_ext_op();
    for (int i = 0; i < 10; i++) begin
      ext_req = 1'b1;
      tick();
      pat[9-i] = d_ack;
      rpat[9-i] = d_run;
      if (m_ack) new_ext_op();
    end
    check("t3_ack_pattern", 16'(pat), 16'(10'b0111101111));
    check("t3_run_pattern", 16'(rpat), 16'(10'b1000010000));
    ext_req = 1'b0;
    repeat (2) tick();

    // external high-byte write while the core tries to write the same word
    ext_addr = 16'h0100; ext_wr = WR_HI; ext_wdata = 16'h12AB; ext_req = 1'b1;
    tick();
    cpu_addr = 16'h0100; cpu_wr = WR_WORD; cpu_wdata = 16'hFFFF;
    tick();
    check("t4_byte_write", ram[16'h0100], 16'h1266);
    ext_req = 1'b0; ext_wr = WR_NONE;
    tick();
    check("t4_cpu_blocked", ram[16'h0100], 16'h1266);
    tick();
    check("t4_cpu_after", ram[16'h0100], 16'hFFFF);
    cpu_wr = WR_NONE;
    tick();

    // reset in the third EXT cycle of a burst
    ext_addr = 16'h0090; ext_wr = WR_NONE; ext_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      reset = (i == 3);
      tick();
      pat[9-i] = d_ack;
    end
    check("t6_ack_pattern", 16'(pat), 16'(10'b0110011110));
    ext_req = 1'b0;
    repeat (2) tick();

    // core program interleaved with random external traffic
    cpu_idx = 0;
    cyc = 0;
    while (cpu_idx < NCPU && cyc < 4000) begin
      run_in = ($urandom_range(0, 9) != 0);
      cpu_addr = c_addr[cpu_idx]; cpu_wdata = c_dat[cpu_idx];
      cpu_rd = run_in && (c_wr[cpu_idx] == WR_NONE);
      cpu_wr = run_in ? c_wr[cpu_idx] : WR_NONE;
      if (!ext_pend && $urandom_range(0, 2) == 0) begin
        new_ext_op();
        ext_pend = 1'b1;
      end
      ext_req = ext_pend;
      tick();
      cyc++;
      if (m_run) cpu_idx++;
      if (m_ack) ext_pend = 1'b0;
    end
    check("cpu_progress", 16'(cpu_idx), 16'(NCPU));
    cpu_rd = 1'b0; cpu_wr = WR_NONE; ext_req = 1'b0; run_in = 1'b1;
    repeat (2) tick();
    for (int i = 0; i < 64; i++) check("final_ram", ram[i], golden[i]);

    mon_on = 1'b0;
    check("scoreboard_drained", 16'(sb.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
